// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding AXI-lite style read per instruction,
// handing each fetched word to decode and waiting for writeback before the next.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_pre_i,
  output logic        ready_pre_o,
  input  logic        branch_en_i,
  input  logic [31:0] dnpc_i,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        valid_post_o,
  input  logic        ready_post_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        fetch_err_o,
  output logic [31:0] fetch_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        err;
  logic [31:0] fetch_cnt;

  // pc only changes in WAIT, so it still names the delivered instruction in OUT
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      err       <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      case (state)
        S_IDLE: state <= S_AR;
        S_AR: begin
          if (arready_i) state <= S_R;
        end
        S_R: begin
          if (rvalid_i) begin
            inst  <= rdata_i;
            err   <= (rresp_i != 2'b00);
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (ready_post_i) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (valid_pre_i) begin
            pc    <= branch_en_i ? (dnpc_i & ~32'h3) : (pc + 32'd4);
            state <= S_AR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // handshake outputs depend on the state register alone
  assign arvalid_o    = (state == S_AR);
  assign rready_o     = (state == S_R);
  assign valid_post_o = (state == S_OUT);
  assign ready_pre_o  = (state == S_WAIT);

  assign araddr_o    = pc;
  assign pc_o        = pc;
  assign inst_o      = inst;
  assign fetch_err_o = err;
  assign fetch_cnt_o = fetch_cnt;

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: a memory/writeback model drives stimulus and queues the
// expected deliveries; a negedge monitor pops and compares every accepted delivery.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_pre_i = 1'b0;
  logic        ready_pre_o;
  logic        branch_en_i = 1'b0;
  logic [31:0] dnpc_i = 32'h0;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic        valid_post_o;
  logic        ready_post_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fetch_err_o;
  logic [31:0] fetch_cnt_o;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .branch_en_i(branch_en_i), .dnpc_i(dnpc_i),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o), .fetch_cnt_o(fetch_cnt_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic [31:0] dnpc;
  } br_t;

  exp_t sb_q[$];
  br_t  br_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory contents and response are pure functions of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a[5:2] == 4'hB) ? 2'b10 : 2'b00;
  endfunction

  // Architectural model: next PC and delivery index
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_cnt = 32'h0;

  task automatic push_exp();
    exp_t e;
    e.pc   = m_pc;
    e.inst = mem_word(m_pc);
    e.err  = (mem_resp(m_pc) != 2'b00);
    e.cnt  = m_cnt;
    sb_q.push_back(e);
    m_cnt = m_cnt + 32'd1;
  endtask

  int p_ar = 100, p_post = 100, p_pre = 100;
  int rdly_min = 0, rdly_max = 0;
  bit rst_req = 1'b1;
  bit mem_busy = 1'b0;
  bit ar_fire = 1'b0, r_fire = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int rdly = 0;
  bit zw = 1'b0;

  task automatic cycle();
    br_t b;
    @(posedge clk);
    #1;
    if (ar_fire) begin
      mem_busy = 1'b1;
      rdly = $urandom_range(rdly_max, rdly_min);
    end
    if (r_fire) mem_busy = 1'b0;
    ar_fire = 1'b0;
    r_fire  = 1'b0;
    if (rst_req) begin
      mem_busy = 1'b0;
      sb_q.delete();
    end else if (!rst) begin
      m_pc  = RESET_PC;
      m_cnt = 32'h0;
      push_exp();
    end
    rst = !rst_req;

    arready_i = ($urandom_range(99, 0) < p_ar);
    if (mem_busy && rdly == 0) begin
      rvalid_i = 1'b1;
      rdata_i  = mem_word(mem_addr);
      rresp_i  = mem_resp(mem_addr);
    end else begin
      if (mem_busy) begin
        rdly--;
        rvalid_i = 1'b0;
      end else begin
        rvalid_i = $urandom_range(1, 0);
      end
      rdata_i = $urandom;
      rresp_i = $urandom_range(3, 0);
    end
    ready_post_i = ($urandom_range(99, 0) < p_post);
    valid_pre_i  = ($urandom_range(99, 0) < p_pre);
    branch_en_i  = $urandom_range(1, 0);
    dnpc_i       = $urandom;

    if (!rst_req) begin
      if (valid_pre_i && ready_pre_o) begin
        if (br_q.size() != 0) begin
          b = br_q.pop_front();
          branch_en_i = b.en;
          dnpc_i      = b.dnpc;
        end
        m_pc = branch_en_i ? {dnpc_i[31:2], 2'b00} : m_pc + 32'd4;
        push_exp();
      end
      if (arvalid_o && arready_i) begin
        ar_fire  = 1'b1;
        mem_addr = araddr_o;
      end
      if (rready_o && rvalid_i) r_fire = 1'b1;
    end
  endtask

  // Monitor
  exp_t e_m;
  logic [31:0] mon_cnt = 32'h0;
  int mon_cyc = 0, last_del_cyc = 0;
  bit last_del_zw = 1'b0;
  bit prev_ar_stall = 1'b0, prev_out_stall = 1'b0;
  logic [31:0] prev_addr, prev_pc, prev_inst;
  logic prev_err;
  int err_seen = 0, ok_seen = 0, deliveries = 0;

  always @(negedge clk) begin
    mon_cyc++;
    if (!rst) begin
      mon_cnt = 32'h0;
      prev_ar_stall = 1'b0;
      prev_out_stall = 1'b0;
      last_del_zw = 1'b0;
    end else begin
      chk("cnt_track", fetch_cnt_o, mon_cnt);
      chk("onehot_ctl", {31'h0, $onehot0({arvalid_o, rready_o, valid_post_o, ready_pre_o})}, 32'h1);
      if (prev_ar_stall) begin
        chk("ar_hold_valid", {31'h0, arvalid_o}, 32'h1);
        chk("ar_hold_addr", araddr_o, prev_addr);
      end
      if (prev_out_stall) begin
        chk("out_hold_valid", {31'h0, valid_post_o}, 32'h1);
        chk("out_hold_pc", pc_o, prev_pc);
        chk("out_hold_inst", inst_o, prev_inst);
        chk("out_hold_err", {31'h0, fetch_err_o}, {31'h0, prev_err});
      end
      if (valid_post_o && ready_post_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=delivery pc=%h required=no delivery", pc_o);
        end else begin
          e_m = sb_q.pop_front();
          chk("del_pc", pc_o, e_m.pc);
          chk("del_inst", inst_o, e_m.inst);
          chk("del_err", {31'h0, fetch_err_o}, {31'h0, e_m.err});
          chk("del_cnt", fetch_cnt_o, e_m.cnt);
          if (e_m.err) err_seen++; else ok_seen++;
        end
        if (zw && last_del_zw) chk("zero_wait_period", mon_cyc - last_del_cyc, 32'd4);
        last_del_cyc = mon_cyc;
        last_del_zw  = zw;
        mon_cnt = mon_cnt + 32'd1;
        deliveries++;
      end
      prev_ar_stall  = arvalid_o && !arready_i;
      prev_out_stall = valid_post_o && !ready_post_i;
      prev_addr = araddr_o;
      prev_pc   = pc_o;
      prev_inst = inst_o;
      prev_err  = fetch_err_o;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, {31'h0, arvalid_o}, 32'h0);
    chk({tag, "_rready"}, {31'h0, rready_o}, 32'h0);
    chk({tag, "_valid_post"}, {31'h0, valid_post_o}, 32'h0);
    chk({tag, "_ready_pre"}, {31'h0, ready_pre_o}, 32'h0);
    chk({tag, "_araddr"}, araddr_o, RESET_PC);
    chk({tag, "_pc"}, pc_o, RESET_PC);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_err"}, {31'h0, fetch_err_o}, 32'h0);
    chk({tag, "_cnt"}, fetch_cnt_o, 32'h0);
  endtask

  int waited;

  initial begin
    // Reset, then check the idle output state
    rst_req = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    chk_reset_outputs("reset");

    // Zero-wait memory and always-ready neighbours, with a fall-through then a branch
    p_ar = 100; p_post = 100; p_pre = 100; rdly_min = 0; rdly_max = 0;
    br_q.push_back('{1'b0, 32'h0});
    br_q.push_back('{1'b1, 32'h8000_0103});
    zw = 1'b1;
    rst_req = 1'b0;
    repeat (30) cycle();
    zw = 1'b0;

    // Address stall then delivery stall
    p_ar = 0;
    repeat (8) cycle();
    p_ar = 100; p_post = 0;
    repeat (12) cycle();
    p_post = 100;

    // Randomized traffic with PC wrap and error-response fetches forced in
    p_ar = 50; p_post = 50; p_pre = 50; rdly_min = 0; rdly_max = 3;
    br_q.push_back('{1'b1, 32'hFFFF_FFFE});
    br_q.push_back('{1'b0, 32'h0});
    br_q.push_back('{1'b1, 32'h8000_002C});
    br_q.push_back('{1'b0, 32'h0});
    repeat (400) cycle();

    // Reset asserted while waiting for read data
    rdly_min = 6; rdly_max = 6; p_ar = 100;
    waited = 0;
    while (!rready_o && waited < 60) begin
      cycle();
      waited++;
    end
    chk("reach_r_state", {31'h0, rready_o}, 32'h1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    rdly_min = 0; rdly_max = 3;
    cycle();
    @(negedge clk);
    chk_reset_outputs("midr_reset");

    p_ar = 60; p_post = 60; p_pre = 60;
    repeat (200) cycle();
    p_ar = 100; p_post = 100; p_pre = 100;
    repeat (20) cycle();

    @(negedge clk);
    chk("saw_err_delivery", {31'h0, err_seen > 0}, 32'h1);
    chk("saw_ok_delivery", {31'h0, ok_seen > 0}, 32'h1);
    chk("enough_deliveries", {31'h0, deliveries > 30}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-low (asserted when rst==0).
REQ-004 SHALL have port valid_pre_i, input, 1, meaning the writeback stage reports the current instruction retired.
REQ-005 SHALL have port ready_pre_o, output, 1, meaning the IFU accepts the retire/redirect handshake.
REQ-006 SHALL have port branch_en_i, input, 1, meaning take the redirect target, sampled with valid_pre_i.
REQ-007 SHALL have port dnpc_i, input, 32, the redirect target PC.
REQ-008 SHALL have port araddr_o, output, 32, the memory read address.
REQ-009 SHALL have port arvalid_o, output, 1, meaning the read address is valid.
REQ-010 SHALL have port arready_i, input, 1, meaning memory accepts the address.
REQ-011 SHALL have port rdata_i, input, 32, the memory read data (instruction word).
REQ-012 SHALL have port rresp_i, input, 2, the read response (2'b00 = OKAY).
REQ-013 SHALL have port rvalid_i, input, 1, meaning read data is valid.
REQ-014 SHALL have port rready_o, output, 1, meaning the IFU accepts read data.
REQ-015 SHALL have port valid_post_o, output, 1, meaning pc_o/inst_o hold a fetched instruction for the IDU.
REQ-016 SHALL have port ready_post_i, input, 1, meaning the IDU latches pc_o/inst_o.
REQ-017 SHALL have port pc_o, output, 32, the PC of the delivered instruction.
REQ-018 SHALL have port inst_o, output, 32, the delivered instruction word.
REQ-019 SHALL have port fetch_err_o, output, 1, meaning rresp_i was non-OKAY for the delivered instruction.
REQ-020 SHALL have port fetch_cnt_o, output, 32, the count of instructions delivered to the IDU.

Function
REQ-021 SHALL implement the states IDLE, AR, R, OUT and WAIT, one-hot or encoded, with a registered state.
REQ-022 IDLE SHALL be the reset state and SHALL move to AR unconditionally on the first cycle with rst==1.
REQ-023 In AR: arvalid_o=1 and araddr_o=pc; on arvalid_o&&arready_i the FSM SHALL move to R; araddr_o SHALL stay stable while stalled.
REQ-024 In R: rready_o=1; on rvalid_i the FSM SHALL latch inst<=rdata_i and err<=(rresp_i!=2'b00), then move to OUT.
REQ-025 In OUT: valid_post_o=1 with pc_o/inst_o/fetch_err_o stable; on ready_post_i the FSM SHALL increment fetch_cnt_o by 1 (mod 2^32) and move to WAIT.
REQ-026 In WAIT: ready_pre_o=1; on valid_pre_i, pc SHALL load {dnpc_i[31:2],2'b00} if branch_en_i, else pc+4 (mod 2^32), and the FSM SHALL move to AR.
REQ-027 arvalid_o, rready_o, valid_post_o and ready_pre_o SHALL be decoded from the state register only, with no combinational path from any input.
REQ-028 valid_pre_i outside WAIT, rvalid_i outside R, and arready_i outside AR SHALL be ignored with no state change.
REQ-029 Handshake latency: AR->R, R->OUT, OUT->WAIT and WAIT->AR SHALL each take exactly one cycle after the enabling handshake, so a zero-wait memory with an always-ready IDU and writeback gives 4 cycles per instruction.
REQ-030 A fetch error SHALL NOT stall the FSM; the instruction is delivered with fetch_err_o=1, and err is cleared on the next R-state capture.
REQ-031 pc_o SHALL equal the address issued in AR for the instruction being delivered.

Reset
REQ-032 While rst==0 at a clock edge: state<=IDLE, pc<=RESET_PC, inst<=32'h0, err<=0, fetch_cnt_o<=0; in-flight AXI transactions are abandoned.
REQ-033 After reset: arvalid_o=0, rready_o=0, valid_post_o=0, ready_pre_o=0, araddr_o=pc_o=RESET_PC, inst_o=0 and fetch_err_o=0.

Verification
REQ-034 Release reset; memory with arready=1 and rvalid one cycle later returns 32'h00000413 -> araddr_o=0x80000000; valid_post_o=1 with inst_o=0x00000413; after ready_post_i, fetch_cnt_o=1.
REQ-035 Retire with branch_en_i=0 -> next araddr_o=0x80000004; retire with branch_en_i=1 and dnpc_i=0x80000103 -> araddr_o=0x80000100.
REQ-036 Hold arready_i=0 for 5 cycles, then hold ready_post_i=0 for 3 cycles -> arvalid_o/araddr_o stable and valid_post_o/inst_o stable throughout; no extra fetch_cnt_o increment.
REQ-037 rresp_i=2'b10 on a fetch -> fetch_err_o=1 for that delivery; the next OKAY fetch gives fetch_err_o=0.
REQ-038 With pc=0xFFFFFFFC, retire with branch_en_i=0 -> araddr_o=0x00000000; assert rst==0 while in R -> state IDLE, pc=RESET_PC, fetch_cnt_o=0, and a later rvalid_i is ignored until the next R state.
